ctrl_pipe_regs: RTL and testbench

//   Receiving end of the control-unit interface. Captures the decode-stage control word (flags,
//   alu_cont, ext_cont) and carries it through the EX, MEM and WB pipeline registers.

---
 rtl/ctrl_pipe_regs.sv | 189 ++++++++++++++++++
 tb/tb_ctrl_pipe_regs.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_regs.sv
// Control-word pipeline (EX/MEM/WB) with EX-stage branch resolution and decode stall/flush.
// Define FORWARD_EN to add forwarding selects and reduce the stall rule to load-use only.
`timescale 1ns/1ps
module ctrl_pipe_regs #(
  parameter int REG_W  = 5,
  parameter int ALU_CW = 3,
  parameter int EXT_CW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [7:0]        d_flags,
  input  logic [ALU_CW-1:0] d_alu_cont,
  input  logic [EXT_CW-1:0] d_ext_cont,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic [REG_W-1:0]  d_rd,
  input  logic              e_zero,
  output logic [ALU_CW-1:0] e_alu_cont,
  output logic [EXT_CW-1:0] e_ext_cont,
  output logic              e_alu_src,
  output logic              m_mem_write,
  output logic [REG_W-1:0]  m_write_reg,
  output logic              w_reg_write,
  output logic              w_mem_to_reg,
  output logic              w_jal,
  output logic [REG_W-1:0]  w_write_reg,
  output logic              pc_src_e,
  output logic              flush_d,
`ifdef FORWARD_EN
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [REG_W-1:0]  e_rs,
  output logic [REG_W-1:0]  e_rt,
`endif
  output logic              stall_d
);

  localparam int F_JAL        = 7;
  localparam int F_JUMP       = 6;
  localparam int F_REG_WRITE  = 5;
  localparam int F_REG_DST    = 4;
  localparam int F_ALU_SRC    = 3;
  localparam int F_BRANCH     = 2;
  localparam int F_MEM_WRITE  = 1;
  localparam int F_MEM_TO_REG = 0;
  localparam logic [REG_W-1:0] LINK_REG = REG_W'(31);

  typedef struct packed {
    logic              valid;
    logic              jal;
    logic              jump;
    logic              reg_write;
    logic              alu_src;
    logic              branch;
    logic              mem_write;
    logic              mem_to_reg;
    logic [ALU_CW-1:0] alu_cont;
    logic [EXT_CW-1:0] ext_cont;
    logic [REG_W-1:0]  write_reg;
`ifdef FORWARD_EN
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
`endif
  } ex_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
    logic             jal;
    logic [REG_W-1:0] write_reg;
  } mem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic             jal;
    logic [REG_W-1:0] write_reg;
  } wb_t;

  ex_t  e_q, e_d;
  mem_t m_q, m_d;
  wb_t  w_q, w_d;
  logic redirect, hazard, bubble;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reads_reg(input logic [REG_W-1:0] wr,
                                     input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (wr != '0) && ((wr == a) || (wr == b));
  endfunction

`ifdef FORWARD_EN
  function automatic logic src_hit(input logic valid, input logic reg_write,
                                   input logic [REG_W-1:0] wr, input logic [REG_W-1:0] src);
    return valid && reg_write && (wr != '0) && (wr == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
    if (src_hit(m_q.valid, m_q.reg_write, m_q.write_reg, src)) return 2'b10;
    if (src_hit(w_q.valid, w_q.reg_write, w_q.write_reg, src)) return 2'b01;
    return 2'b00;
  endfunction
`endif

  always_comb begin
    pc_src_e = e_q.valid & e_q.branch & e_zero;
    redirect = pc_src_e | (e_q.valid & e_q.jump);
`ifdef FORWARD_EN
    hazard = e_q.valid & e_q.mem_to_reg & reads_reg(e_q.write_reg, d_rs, d_rt);
`else
    // WB is excluded: the register file writes in the first half and reads in the second.
    hazard = (e_q.valid & e_q.reg_write & reads_reg(e_q.write_reg, d_rs, d_rt)) |
             (m_q.valid & m_q.reg_write & reads_reg(m_q.write_reg, d_rs, d_rt));
`endif
    flush_d = redirect;
    stall_d = d_valid & hazard & ~redirect;
    bubble  = ~d_valid | stall_d | flush_d;
  end

  always_comb begin
    e_d = '0;
    if (!bubble) begin
      e_d.valid      = 1'b1;
      e_d.jal        = d_flags[F_JAL];
      e_d.jump       = d_flags[F_JUMP];
      e_d.reg_write  = d_flags[F_REG_WRITE];
      e_d.alu_src    = d_flags[F_ALU_SRC];
      e_d.branch     = d_flags[F_BRANCH];
      e_d.mem_write  = d_flags[F_MEM_WRITE];
      e_d.mem_to_reg = d_flags[F_MEM_TO_REG];
      e_d.alu_cont   = d_alu_cont;
      e_d.ext_cont   = d_ext_cont;
      e_d.write_reg  = d_flags[F_JAL] ? LINK_REG : (d_flags[F_REG_DST] ? d_rd : d_rt);
`ifdef FORWARD_EN
      e_d.rs         = d_rs;
      e_d.rt         = d_rt;
`endif
    end

    m_d            = '0;
    m_d.valid      = e_q.valid;
    m_d.reg_write  = e_q.valid & e_q.reg_write;
    m_d.mem_write  = e_q.valid & e_q.mem_write;
    m_d.mem_to_reg = e_q.mem_to_reg;
    m_d.jal        = e_q.jal;
    m_d.write_reg  = e_q.write_reg;

    w_d            = '0;
    w_d.valid      = m_q.valid;
    w_d.reg_write  = m_q.valid & m_q.reg_write;
    w_d.mem_to_reg = m_q.mem_to_reg;
    w_d.jal        = m_q.jal;
    w_d.write_reg  = m_q.write_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign e_alu_cont   = e_q.alu_cont;
  assign e_ext_cont   = e_q.ext_cont;
  assign e_alu_src    = e_q.alu_src;
  assign m_mem_write  = m_q.mem_write;
  assign m_write_reg  = m_q.write_reg;
  assign w_reg_write  = w_q.valid & w_q.reg_write;
  assign w_mem_to_reg = w_q.mem_to_reg;
  assign w_jal        = w_q.jal;
  assign w_write_reg  = w_q.write_reg;

`ifdef FORWARD_EN
  assign fwd_a_e = fwd_sel(e_q.rs);
  assign fwd_b_e = fwd_sel(e_q.rt);
  assign e_rs    = e_q.rs;
  assign e_rt    = e_q.rt;
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Bench for ctrl_pipe_regs: table of decode words with expected stall/flush, plus a
// scoreboard queue holding the expected EX/MEM/WB control of each decode cycle.
`timescale 1ns/1ps
module tb_ctrl_pipe_regs;

  localparam int OP_ADD = 'h30;  // reg_write | reg_dst
  localparam int OP_LW  = 'h29;  // reg_write | alu_src | mem_to_reg
  localparam int OP_BEQ = 'h04;  // branch
  localparam int OP_JAL = 'hE0;  // jal | jump | reg_write
  localparam int A_ADD  = 2;
  localparam int A_SUB  = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_valid;
  logic [7:0] d_flags;
  logic [2:0] d_alu_cont;
  logic [3:0] d_ext_cont;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       e_zero;
  logic [2:0] e_alu_cont;
  logic [3:0] e_ext_cont;
  logic       e_alu_src, m_mem_write, w_reg_write, w_mem_to_reg, w_jal;
  logic [4:0] m_write_reg, w_write_reg;
  logic       pc_src_e, flush_d, stall_d;
`ifdef FORWARD_EN
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [4:0] e_rs, e_rt;
`endif

  ctrl_pipe_regs dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_flags(d_flags),
    .d_alu_cont(d_alu_cont), .d_ext_cont(d_ext_cont),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .e_zero(e_zero),
    .e_alu_cont(e_alu_cont), .e_ext_cont(e_ext_cont), .e_alu_src(e_alu_src),
    .m_mem_write(m_mem_write), .m_write_reg(m_write_reg),
    .w_reg_write(w_reg_write), .w_mem_to_reg(w_mem_to_reg), .w_jal(w_jal),
    .w_write_reg(w_write_reg), .pc_src_e(pc_src_e), .flush_d(flush_d),
`ifdef FORWARD_EN
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .e_rs(e_rs), .e_rt(e_rt),
`endif
    .stall_d(stall_d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dv;
    logic [7:0] fl;
    logic [2:0] alu;
    logic [3:0] ext;
    logic [4:0] rs, rt, rd;
    logic       zero;
    logic       pc, fd, st;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct packed {
    logic [2:0] alu;
    logic [3:0] ext;
    logic       alu_src, mem_write, reg_write, mem_to_reg, jal;
    logic [4:0] wr;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   stepno = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t vec(input int dv, input int fl, input int alu, input int ext,
                               input int rs, input int rt, input int rd, input int zero,
                               input int pc, input int fd, input int st,
                               input int fa, input int fb);
    vec_t r;
    r.dv = 1'(dv);   r.fl = 8'(fl);   r.alu = 3'(alu); r.ext = 4'(ext);
    r.rs = 5'(rs);   r.rt = 5'(rt);   r.rd = 5'(rd);   r.zero = 1'(zero);
    r.pc = 1'(pc);   r.fd = 1'(fd);   r.st = 1'(st);
    r.fa = 2'(fa);   r.fb = 2'(fb);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %0h, expected %0h", stepno, nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " e_alu_cont"},   32'(e_alu_cont),   32'd0);
    chk({tag, " e_ext_cont"},   32'(e_ext_cont),   32'd0);
    chk({tag, " e_alu_src"},    32'(e_alu_src),    32'd0);
    chk({tag, " m_mem_write"},  32'(m_mem_write),  32'd0);
    chk({tag, " m_write_reg"},  32'(m_write_reg),  32'd0);
    chk({tag, " w_reg_write"},  32'(w_reg_write),  32'd0);
    chk({tag, " w_mem_to_reg"}, 32'(w_mem_to_reg), 32'd0);
    chk({tag, " w_jal"},        32'(w_jal),        32'd0);
    chk({tag, " w_write_reg"},  32'(w_write_reg),  32'd0);
    chk({tag, " pc_src_e"},     32'(pc_src_e),     32'd0);
    chk({tag, " flush_d"},      32'(flush_d),      32'd0);
    chk({tag, " stall_d"},      32'(stall_d),      32'd0);
`ifdef FORWARD_EN
    chk({tag, " fwd_a_e"},      32'(fwd_a_e),      32'd0);
    chk({tag, " fwd_b_e"},      32'(fwd_b_e),      32'd0);
`endif
  endtask

  task automatic prime_sb();
    sb.delete();
    repeat (3) sb.push_back('0);
  endtask

  // Entered 1ns after a rising edge; returns 1ns after the next one.
  task automatic step(input vec_t v);
    exp_t cap, ee, em, ew;
    d_valid = v.dv; d_flags = v.fl; d_alu_cont = v.alu; d_ext_cont = v.ext;
    d_rs = v.rs; d_rt = v.rt; d_rd = v.rd; e_zero = v.zero;
    #3;
    chk("pc_src_e", 32'(pc_src_e), 32'(v.pc));
    chk("flush_d",  32'(flush_d),  32'(v.fd));
    chk("stall_d",  32'(stall_d),  32'(v.st));
`ifdef FORWARD_EN
    chk("fwd_a_e",  32'(fwd_a_e),  32'(v.fa));
    chk("fwd_b_e",  32'(fwd_b_e),  32'(v.fb));
`endif
    if (sb.size() != 3) begin
      chk("scoreboard_depth", 32'(sb.size()), 32'd3);
    end else begin
      ee = sb[2]; em = sb[1]; ew = sb[0];
      chk("e_alu_cont",   32'(e_alu_cont),   32'(ee.alu));
      chk("e_ext_cont",   32'(e_ext_cont),   32'(ee.ext));
      chk("e_alu_src",    32'(e_alu_src),    32'(ee.alu_src));
      chk("m_mem_write",  32'(m_mem_write),  32'(em.mem_write));
      chk("m_write_reg",  32'(m_write_reg),  32'(em.wr));
      chk("w_reg_write",  32'(w_reg_write),  32'(ew.reg_write));
      chk("w_mem_to_reg", 32'(w_mem_to_reg), 32'(ew.mem_to_reg));
      chk("w_jal",        32'(w_jal),        32'(ew.jal));
      chk("w_write_reg",  32'(w_write_reg),  32'(ew.wr));
      void'(sb.pop_front());
    end
    cap = '0;
    if (v.dv && !v.st && !v.fd) begin
      cap.alu        = v.alu;
      cap.ext        = v.ext;
      cap.alu_src    = v.fl[3];
      cap.mem_write  = v.fl[1];
      cap.reg_write  = v.fl[5];
      cap.mem_to_reg = v.fl[0];
      cap.jal        = v.fl[7];
      cap.wr         = v.fl[7] ? 5'd31 : (v.fl[4] ? v.rd : v.rt);
    end
    sb.push_back(cap);
    @(posedge clk);
    #1;
    stepno++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    d_valid = 1'b0; d_flags = '0; d_alu_cont = '0; d_ext_cont = '0;
    d_rs = '0; d_rt = '0; d_rd = '0; e_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prime_sb();

    //                dv fl      alu    ext rs  rt  rd  z  pc fd st fa fb
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  1,  2,  3,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_SUB, 0,  4,  5,  6,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_BEQ, A_SUB, 2,  7,  7,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0, 11, 12, 10,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0, 10,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    // taken beq: wrong-path add is killed, next add proceeds
    tbl.push_back(vec(1, OP_BEQ, A_SUB, 2,  1,  1,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  1,  2, 13,  1, 1, 1, 0, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  1,  2, 14,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  1, 0, 0, 0, 0, 0));
    // lw $8 then add $9,$8,$1
    tbl.push_back(vec(1, OP_LW,  A_ADD, 1,  1,  8,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  8,  1,  9,  0, 0, 0, 1, 0, 0));
`ifdef FORWARD_EN
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  8,  1,  9,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 1, 0));
`else
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  8,  1,  9,  0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  8,  1,  9,  0, 0, 0, 0, 0, 0));
`endif
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    // add $8 then sub $10,$8,$3
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  1,  2,  8,  0, 0, 0, 0, 0, 0));
`ifdef FORWARD_EN
    tbl.push_back(vec(1, OP_ADD, A_SUB, 0,  8,  3, 10,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 2, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
`else
    tbl.push_back(vec(1, OP_ADD, A_SUB, 0,  8,  3, 10,  0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_SUB, 0,  8,  3, 10,  0, 0, 0, 1, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_SUB, 0,  8,  3, 10,  0, 0, 0, 0, 0, 0));
`endif
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    // lw $8, jal, then a reader of $8/$31: redirect beats the stall
    tbl.push_back(vec(1, OP_LW,  A_ADD, 1,  1,  8,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_JAL, A_ADD, 3,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  8, 31,  9,  0, 0, 1, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    // writes to $0 never create a hazard or a forward
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  1,  2,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(1, OP_ADD, A_ADD, 0,  0,  0,  5,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(vec(0, 0,      0,     0,  0,  0,  0,  0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous reset with two adds in flight.
    step(vec(1, OP_ADD, A_ADD, 0, 1, 2, 7, 0, 0, 0, 0, 0, 0));
    step(vec(1, OP_ADD, A_ADD, 0, 4, 5, 9, 0, 0, 0, 0, 0, 0));
    d_valid = 1'b1; d_flags = 8'(OP_ADD); d_alu_cont = 3'(A_SUB); d_ext_cont = '0;
    d_rs = 5'd7; d_rt = 5'd9; d_rd = 5'd10; e_zero = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    d_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prime_sb();
    step(vec(1, OP_ADD, A_SUB, 0, 7, 9, 10, 0, 0, 0, 0, 0, 0));
    repeat (3) step(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
